miss_fill_ctrl: RTL

- Read-miss fill controller on the RAM-to-cache return path. It complements the write-enable path, which carries data from the CPU toward the cache and RAM.
- On a CPU read miss it issues a single read to RAM and waits out the fixed RAM latency. It then writes the returned word into the cache and presents that word to the CPU with a one-cycle valid pulse.
- It raises stall for the whole miss.
- It sits between the cache controller (hit, re) and the RAM read port.

---
 rtl/miss_fill_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/miss_fill_ctrl.sv
// Read-miss fill controller: fetches a missed word from RAM,
// writes it into the cache and returns it to the CPU.
module miss_fill_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int RAM_LATENCY = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re,
    input  logic                  hit,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] RAM_rdata,
    output logic                  RAM_re,
    output logic [ADDR_WIDTH-1:0] RAM_addr,
    output logic                  cache_we,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  stall,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FILL,
        DONE
    } state_t;

    localparam int LW = $clog2(RAM_LATENCY + 1);
    localparam logic [LW-1:0] LAT_LOAD = LW'(RAM_LATENCY - 1);

    state_t                state;
    state_t                state_nx;
    logic [LW-1:0]         lat_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  accept;
    logic                  lat_done;

    assign accept   = (state == IDLE) && re && !hit;
    assign lat_done = (lat_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = REQ;
            REQ:     state_nx = WAIT;
            WAIT:    if (lat_done) state_nx = FILL;
            FILL:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers; counter saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                addr_q <= addr;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (state == REQ) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == WAIT && !lat_done) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (state == WAIT && lat_done) begin
                data_q <= RAM_rdata;
            end
        end
    end

    always_comb begin
        RAM_re      = 1'b0;
        RAM_addr    = '0;
        cache_we    = 1'b0;
        cache_addr  = '0;
        cache_wdata = '0;
        rd_valid    = 1'b0;
        rd_data     = data_q;
        stall       = (state != IDLE);
        miss_count  = cnt_q;
        unique case (state)
            REQ: begin
                RAM_re   = 1'b1;
                RAM_addr = addr_q;
            end
            FILL: begin
                cache_we    = 1'b1;
                cache_addr  = addr_q;
                cache_wdata = data_q;
            end
            DONE:    rd_valid = 1'b1;
            default: ;
        endcase
    end

endmodule
